bp_fe_fetch_queue: RTL and testbench
====================================

Name: bp_fe_fetch_queue

Overview:
- Decoupling FIFO directly downstream of the FE PC generator.
- Buffers fetch/exception messages (bp_fe_pc_gen_queue_s) bound for the backend.
- Gives PC gen a simple ready signal.
- Discards stale wrong-path fetches when the backend issues a PC redirect (flush).

Parameters:
- msg_width_p, 104: width of one queue message (bp_fe_pc_gen_queue_s); opaque to this block.
- els_p, 8: entry count; power of two, ≥2.
- ptr_width_lp, $clog2(els_p): local; entry index width.
- cnt_width_lp, $clog2(els_p+1): local; occupancy width.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- fe_queue_i  in  msg_width_p  message from PC gen (pc_gen_fe_o)
- fe_queue_v_i  in  1  message valid (pc_gen_fe_v_o)
- fe_queue_ready_o  out  1  queue can accept (to pc_gen_fe_ready_i)
- fe_queue_o  out  msg_width_p  head message to backend
- fe_queue_v_o  out  1  head valid
- fe_queue_yumi_i  in  1  backend consumes head this cycle; legal only when fe_queue_v_o=1
- flush_i  in  1  backend redirect; discard all contents
- count_o  out  cnt_width_lp  current occupancy

Behaviour:
- Storage:
  - els_p x msg_width_p register array.
  - wptr and rptr, each ptr_width_lp+1 bits (extra wrap bit).
  - empty = (wptr==rptr).
  - full = (index bits equal) & (wrap bits differ).
- Reset: wptr=rptr=0. Outputs after reset: fe_queue_v_o=0, count_o=0, fe_queue_ready_o=1. Array contents are not reset; fe_queue_o is don't-care while v_o=0.
- fe_queue_ready_o = ~full & ~flush_i & ~reset_i. It is combinational from state and flush only, and never depends on yumi_i, so a full queue refuses enqueue even in a dequeue cycle.
- Enqueue: fires when fe_queue_v_i & fe_queue_ready_o. Writes mem[wptr] and increments wptr.
- Dequeue: fires when fe_queue_yumi_i & fe_queue_v_o. Increments rptr.
- fe_queue_v_o = ~empty. fe_queue_o = mem[rptr index].
- Latency: 1 cycle. A message enqueued in cycle N is visible at the head in N+1.
- Simultaneous enqueue and dequeue (non-full, non-empty): both occur; count is unchanged.
- Wrap-around: pointers increment modulo 2*els_p. The index wraps from els_p-1 to 0 and the wrap bit toggles.
- Flush (flush_i=1): priority over everything.
  - Next cycle: wptr=rptr=0, count_o=0, v_o=0.
  - Enqueue and yumi in the flush cycle are ignored.
  - A flush while empty is harmless.
- Reset asserted mid-operation: identical to flush, plus ready_o=0 during reset.
- count_o = wptr - rptr in cnt_width_lp-bit modular arithmetic; range 0..els_p.
- Illegal yumi (yumi_i while v_o=0): ignored, pointer not moved. Covered by an assertion (simulation only).

Optional Feature:
- Macro: BP_FE_FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty and fe_queue_v_i=1, fe_queue_o = fe_queue_i and fe_queue_v_o=1 in the same cycle.
  - If yumi_i is also 1, nothing is written and the pointers hold (zero-latency pass-through).
  - If yumi_i=0, the message is enqueued normally.
  - flush_i still suppresses bypass: v_o=0 in the flush cycle.
- Undefined: strict 1-cycle latency as described above; no combinational path from fe_queue_i/v_i to fe_queue_o/v_o.

Decomposition:
- Shared package bp_fe_pkg holds:
  - bp_fe_pc_gen_queue_s width macro, used by instantiators to set msg_width_p.
  - default fetch-queue depth constant bp_fe_fetch_queue_els_gp = 8.
- Sub-module bp_fe_fetch_queue_ptr: wrap-bit pointer counter with increment and clear inputs, instantiated twice (read/write).

Test Plan:
- Reset, then idle → v_o=0, ready_o=1, count_o=0 for 3 cycles.
- Enqueue 0x11, 0x22, 0x33 on consecutive cycles, yumi held 0 → count_o = 1, 2, 3; head stays 0x11. Then yumi for 3 cycles → outputs 0x11, 0x22, 0x33 in order, then v_o=0.
- Enqueue 8 messages (els_p=8) → count_o=8, ready_o=0. A 9th v_i=1 with yumi=1 is not accepted; the next cycle count_o=7 and ready_o=1.
- Continuous enqueue+dequeue for 20 cycles with values 0..19 → ordering preserved across two pointer wraps; count_o constant at 1.
- Fill 5 entries, then assert flush_i together with v_i=1 and yumi=1 → next cycle count_o=0, v_o=0; the flushed-cycle message never appears at the output.
- With BP_FE_FETCH_QUEUE_BYPASS_EN: empty queue, v_i=1 with 0xAB, yumi=1 → fe_queue_o=0xAB and v_o=1 in the same cycle, count_o stays 0. Without the macro: v_o=0 that cycle and 0xAB appears the next cycle.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - shared front-end constants for the fetch queue and its instantiators
package bp_fe_pkg;

  // Width of one bp_fe_pc_gen_queue_s message; instantiators set msg_width_p from this
  localparam int bp_fe_pc_gen_queue_width_gp = 104;
  localparam int bp_fe_fetch_queue_els_gp    = 8;

endpackage

// File: rtl/bp_fe_fetch_queue_ptr.sv
// rtl/bp_fe_fetch_queue_ptr.sv - wrap-bit pointer counter with increment and clear
module bp_fe_fetch_queue_ptr #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [width_p-1:0] ptr_o
);

  logic [width_p-1:0] r_ptr;

  // The top bit is the wrap flag; natural overflow gives modulo 2*els_p
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= r_ptr + width_p'(1);
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/bp_fe_fetch_queue.sv
// rtl/bp_fe_fetch_queue.sv - PC-gen to backend decoupling FIFO with flush; BP_FE_FETCH_QUEUE_BYPASS_EN adds empty-queue pass-through
module bp_fe_fetch_queue
  import bp_fe_pkg::*;
#(
  parameter  int msg_width_p  = bp_fe_pc_gen_queue_width_gp,
  parameter  int els_p        = bp_fe_fetch_queue_els_gp,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [msg_width_p-1:0]  fe_queue_i,
  input  logic                    fe_queue_v_i,
  output logic                    fe_queue_ready_o,
  output logic [msg_width_p-1:0]  fe_queue_o,
  output logic                    fe_queue_v_o,
  input  logic                    fe_queue_yumi_i,
  input  logic                    flush_i,
  output logic [cnt_width_lp-1:0] count_o
);

  logic [msg_width_p-1:0] r_mem [els_p];

  logic [ptr_width_lp:0] w_wptr;
  logic [ptr_width_lp:0] w_rptr;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_bypass;

  assign w_empty = (w_wptr == w_rptr);
  assign w_full  = (w_wptr[ptr_width_lp-1:0] == w_rptr[ptr_width_lp-1:0])
                 & (w_wptr[ptr_width_lp] != w_rptr[ptr_width_lp]);

  // Deliberately independent of yumi so a full queue never accepts on a dequeue cycle
  assign fe_queue_ready_o = ~w_full & ~flush_i & ~reset_i;

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
  assign w_bypass     = w_empty & fe_queue_v_i & ~flush_i & ~reset_i;
  assign fe_queue_v_o = ~w_empty | w_bypass;
  assign fe_queue_o   = w_bypass ? fe_queue_i : r_mem[w_rptr[ptr_width_lp-1:0]];
  // A bypassed message consumed the same cycle never touches storage
  assign w_enq        = fe_queue_v_i & fe_queue_ready_o & ~(w_bypass & fe_queue_yumi_i);
`else
  assign w_bypass     = 1'b0;
  assign fe_queue_v_o = ~w_empty;
  assign fe_queue_o   = r_mem[w_rptr[ptr_width_lp-1:0]];
  assign w_enq        = fe_queue_v_i & fe_queue_ready_o;
`endif

  assign w_deq = fe_queue_yumi_i & ~w_empty & ~flush_i & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[w_wptr[ptr_width_lp-1:0]] <= fe_queue_i;
    end
  end

  bp_fe_fetch_queue_ptr #(.width_p(ptr_width_lp + 1)) u_wptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .inc_i   (w_enq),
    .ptr_o   (w_wptr)
  );

  bp_fe_fetch_queue_ptr #(.width_p(ptr_width_lp + 1)) u_rptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (flush_i),
    .inc_i   (w_deq),
    .ptr_o   (w_rptr)
  );

  assign count_o = cnt_width_lp'(w_wptr - w_rptr);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_v_o));
    end
  end
`endif

endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// tb/tb_bp_fe_fetch_queue.sv - scoreboard bench for bp_fe_fetch_queue
module tb_bp_fe_fetch_queue;
  import bp_fe_pkg::*;

  localparam int MW = bp_fe_pc_gen_queue_width_gp;
  localparam int CW = $clog2(bp_fe_fetch_queue_els_gp + 1);

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] fe_queue_i;
  logic          fe_queue_v_i;
  logic          fe_queue_ready_o;
  logic [MW-1:0] fe_queue_o;
  logic          fe_queue_v_o;
  logic          fe_queue_yumi_i;
  logic          flush_i;
  logic [CW-1:0] count_o;

  int errors = 0;
  int checks = 0;
  logic [MW-1:0] sb [$];

  always #5 clk = ~clk;

  bp_fe_fetch_queue dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .flush_i          (flush_i),
    .count_o          (count_o)
  );

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected message
  always @(negedge clk) begin
    if (!reset_i && !flush_i && fe_queue_v_o && fe_queue_yumi_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got %0h expected no output", fe_queue_o);
      end else begin
        chk("sb_data", fe_queue_o, sb.pop_front());
      end
    end
  end

  // Drive one cycle's inputs just after the rising edge, return at the falling edge
  task automatic step(input logic v, input logic [MW-1:0] d, input logic y, input logic f);
    @(posedge clk);
    #1;
    fe_queue_v_i    = v;
    fe_queue_i      = d;
    fe_queue_yumi_i = y;
    flush_i         = f;
    @(negedge clk);
  endtask

  initial begin
    reset_i = 1'b1; fe_queue_v_i = 1'b0; fe_queue_i = '0;
    fe_queue_yumi_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      chk("rst_v", MW'(fe_queue_v_o), MW'(0));
      chk("rst_ready", MW'(fe_queue_ready_o), MW'(1));
      chk("rst_count", MW'(count_o), MW'(0));
    end

    sb.push_back(MW'(8'h11)); step(1'b1, MW'(8'h11), 1'b0, 1'b0);
    sb.push_back(MW'(8'h22)); step(1'b1, MW'(8'h22), 1'b0, 1'b0);
    chk("seq_count1", MW'(count_o), MW'(1));
    chk("seq_head1", fe_queue_o, MW'(8'h11));
    sb.push_back(MW'(8'h33)); step(1'b1, MW'(8'h33), 1'b0, 1'b0);
    chk("seq_count2", MW'(count_o), MW'(2));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("seq_count3", MW'(count_o), MW'(3));
    chk("seq_head3", fe_queue_o, MW'(8'h11));
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("seq_drained_v", MW'(fe_queue_v_o), MW'(0));
    chk("seq_drained_count", MW'(count_o), MW'(0));

    for (int k = 0; k < 8; k++) begin
      sb.push_back(MW'(8'hA0 + k));
      step(1'b1, MW'(8'hA0 + k), 1'b0, 1'b0);
    end
    step(1'b1, MW'(8'hFF), 1'b1, 1'b0);
    chk("full_count", MW'(count_o), MW'(8));
    chk("full_ready", MW'(fe_queue_ready_o), MW'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_after_count", MW'(count_o), MW'(7));
    chk("full_after_ready", MW'(fe_queue_ready_o), MW'(1));
    for (int k = 0; k < 7; k++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("full_drained_count", MW'(count_o), MW'(0));

    sb.push_back(MW'(0)); step(1'b1, MW'(0), 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      sb.push_back(MW'(i));
      step(1'b1, MW'(i), 1'b1, 1'b0);
      chk("stream_count", MW'(count_o), MW'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("stream_end_count", MW'(count_o), MW'(0));

    for (int k = 0; k < 5; k++) begin
      sb.push_back(MW'(8'h50 + k));
      step(1'b1, MW'(8'h50 + k), 1'b0, 1'b0);
    end
    step(1'b1, MW'(8'hEE), 1'b1, 1'b1);
    chk("flush_ready", MW'(fe_queue_ready_o), MW'(0));
    sb.delete();
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_count", MW'(count_o), MW'(0));
    chk("flush_v", MW'(fe_queue_v_o), MW'(0));
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_empty_count", MW'(count_o), MW'(0));
    chk("flush_empty_ready", MW'(fe_queue_ready_o), MW'(1));

    step(1'b1, MW'(8'h61), 1'b0, 1'b0);
    step(1'b1, MW'(8'h62), 1'b0, 1'b0);
    @(posedge clk); #1;
    fe_queue_v_i = 1'b0; reset_i = 1'b1;
    @(negedge clk);
    chk("midrst_ready", MW'(fe_queue_ready_o), MW'(0));
    @(posedge clk); #1 reset_i = 1'b0;
    @(negedge clk);
    chk("midrst_count", MW'(count_o), MW'(0));
    chk("midrst_v", MW'(fe_queue_v_o), MW'(0));

`ifdef BP_FE_FETCH_QUEUE_BYPASS_EN
    sb.push_back(MW'(8'hAB));
    step(1'b1, MW'(8'hAB), 1'b1, 1'b0);
    chk("byp_v", MW'(fe_queue_v_o), MW'(1));
    chk("byp_data", fe_queue_o, MW'(8'hAB));
    chk("byp_count", MW'(count_o), MW'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("byp_after_count", MW'(count_o), MW'(0));
    chk("byp_after_v", MW'(fe_queue_v_o), MW'(0));
`else
    sb.push_back(MW'(8'hAB));
    step(1'b1, MW'(8'hAB), 1'b0, 1'b0);
    chk("lat_v0", MW'(fe_queue_v_o), MW'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("lat_v1", MW'(fe_queue_v_o), MW'(1));
    chk("lat_data", fe_queue_o, MW'(8'hAB));
    chk("lat_count", MW'(count_o), MW'(1));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("lat_after_count", MW'(count_o), MW'(0));
`endif

    chk("sb_leftover", MW'(sb.size()), MW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
